branch_resolve: RTL and testbench
=================================

BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/PC width.
REQ-002 SHALL have parameter CNT_W, default 32, statistics counter width.
REQ-003 SHALL have clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have in_valid  input  1  request present.
REQ-006 SHALL have in_ready  output  1  request accepted when in_valid && in_ready.
REQ-007 SHALL have is_branch  input  1  instruction is a conditional branch.
REQ-008 SHALL have br_type  input  3  funct3 condition: BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111.
REQ-009 SHALL have rs1, rs2  input  XLEN  compare operands.
REQ-010 SHALL have pc, imm  input  XLEN  instruction PC and sign-extended B-offset.
REQ-011 SHALL have pred_taken  input  1  front-end prediction.
REQ-012 SHALL have flush  input  1  kill held result.
REQ-013 SHALL have out_valid  output  1  result present; out_ready  input  1  consumer accepts.
REQ-014 SHALL have taken, mispredict  output  1 each; redirect_pc  output  XLEN.
REQ-015 SHALL have stats_clr  input  1; br_cnt, mis_cnt  output  CNT_W each (statistics ports present only under REQ-031).

Function
REQ-016 SHALL compute signed BLT/BGE as two's-complement XLEN compares and BLTU/BGEU as unsigned compares.
REQ-017 SHALL force taken=0 when is_branch=0 or br_type is 010/011.
REQ-018 SHALL set redirect_pc = taken ? pc+imm : pc+4, modulo 2^XLEN (wrap, no overflow flag).
REQ-019 SHALL set mispredict = (taken != pred_taken), including a non-branch with pred_taken=1.
REQ-020 SHALL register all results in one output stage: result appears with out_valid=1 the cycle after acceptance (latency 1).
REQ-021 SHALL drive in_ready = !out_valid || out_ready (combinational; accept-and-drain in one cycle sustains one result per cycle).
REQ-022 SHALL hold taken, mispredict, redirect_pc stable while out_valid && !out_ready.
REQ-023 SHALL clear out_valid on the cycle after flush=1; a request presented during flush is dropped, and in_ready=1 during flush.
REQ-024 SHALL leave output data fields unchanged when no request is accepted.

Reset
REQ-025 SHALL on rst set out_valid=0, taken=0, mispredict=0, redirect_pc=0, br_cnt=0, mis_cnt=0, asynchronously.
REQ-026 SHALL discard any held result on rst mid-transfer; first acceptance possible on the first edge after rst falls.

Configuration
REQ-027 SHALL support macro BRANCH_STATS_EN.
REQ-028 With BRANCH_STATS_EN: br_cnt +1 per out_valid && out_ready transfer with is_branch=1; mis_cnt +1 per such transfer with mispredict=1.
REQ-029 Counters SHALL saturate at 2^CNT_W-1.
REQ-030 stats_clr SHALL zero both counters next edge and take priority over a same-cycle increment; flushed results SHALL NOT count.
REQ-031 Without BRANCH_STATS_EN: stats_clr, br_cnt, mis_cnt ports and counter logic absent; all other behaviour identical.

Structure
REQ-032 SHALL place br_type encodings (BEQ..BGEU) and the PC step constant 4 in the shared core defines package.
REQ-033 SHALL instantiate one sub-module, branch_cond, a purely combinational XLEN-parametrised condition evaluator feeding the output register.

Verification
REQ-034 BLT rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=0x20, pred=0 -> next cycle taken=1, redirect_pc=0x120, mispredict=1.
REQ-035 BLTU same operands, pred=0 -> taken=0, redirect_pc=0x104, mispredict=0.
REQ-036 out_ready=0 for 3 cycles after BEQ result -> outputs held, in_ready=0; out_ready=1 with new in_valid -> drained and reloaded same edge.
REQ-037 flush with in_valid=1 while holding result -> out_valid=0 next cycle; no count change.
REQ-038 BRANCH_STATS_EN, CNT_W=4: 20 mispredicting branches -> br_cnt=mis_cnt=15; stats_clr with concurrent transfer -> both 0.
REQ-039 pc=0xFFFFFFFC, non-branch, pred=1 -> taken=0, redirect_pc=0x0, mispredict=1; rst asserted mid-hold -> out_valid=0 immediately.

Source files
------------

// File: rtl/branch_resolve_pkg.sv
// Shared branch-unit definitions: funct3 condition encodings and the sequential PC step.
package branch_resolve_pkg;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } br_type_e;

  localparam int PC_STEP = 4;

endpackage

// File: rtl/branch_resolve_if.sv
// Request/result bundle for branch_resolve; statistics signals exist only with BRANCH_STATS_EN.
// Handshake: a beat moves on a rising edge where valid && ready; the producer holds its data while valid && !ready.
interface branch_resolve_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);

  logic            in_valid;
  logic            in_ready;
  logic            is_branch;
  logic [2:0]      br_type;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] imm;
  logic            pred_taken;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic            taken;
  logic            mispredict;
  logic [XLEN-1:0] redirect_pc;
`ifdef BRANCH_STATS_EN
  logic             stats_clr;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] mis_cnt;

  modport master (
    output in_valid, is_branch, br_type, rs1, rs2, pc, imm, pred_taken, flush, out_ready, stats_clr,
    input  in_ready, out_valid, taken, mispredict, redirect_pc, br_cnt, mis_cnt
  );
  modport slave (
    input  in_valid, is_branch, br_type, rs1, rs2, pc, imm, pred_taken, flush, out_ready, stats_clr,
    output in_ready, out_valid, taken, mispredict, redirect_pc, br_cnt, mis_cnt
  );
`else
  modport master (
    output in_valid, is_branch, br_type, rs1, rs2, pc, imm, pred_taken, flush, out_ready,
    input  in_ready, out_valid, taken, mispredict, redirect_pc
  );
  modport slave (
    input  in_valid, is_branch, br_type, rs1, rs2, pc, imm, pred_taken, flush, out_ready,
    output in_ready, out_valid, taken, mispredict, redirect_pc
  );
`endif

endinterface

// File: rtl/branch_cond.sv
// Combinational branch condition evaluator; reserved funct3 codes and non-branches never take.
module branch_cond
  import branch_resolve_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            is_branch,
  input  logic [2:0]      br_type,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            taken
);

  always_comb begin
    taken = 1'b0;
    if (is_branch) begin
      case (br_type)
        BR_BEQ:  taken = (rs1 == rs2);
        BR_BNE:  taken = (rs1 != rs2);
        BR_BLT:  taken = ($signed(rs1) <  $signed(rs2));
        BR_BGE:  taken = ($signed(rs1) >= $signed(rs2));
        BR_BLTU: taken = (rs1 <  rs2);
        BR_BGEU: taken = (rs1 >= rs2);
        default: taken = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolution stage: evaluates the condition, registers taken/mispredict/redirect in one
// output slot. Optional transfer statistics under macro BRANCH_STATS_EN.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input logic             clk,
  input logic             rst,
  branch_resolve_if.slave bus
);

  logic            cond_taken;
  logic            accept;
  logic            xfer;
  logic            valid_r;
  logic            taken_r;
  logic            mis_r;
  logic [XLEN-1:0] redirect_r;
  logic [XLEN-1:0] target;

  branch_cond #(.XLEN(XLEN)) u_cond (
    .is_branch (bus.is_branch),
    .br_type   (bus.br_type),
    .rs1       (bus.rs1),
    .rs2       (bus.rs2),
    .taken     (cond_taken)
  );

  // Flush always frees the slot, so the stage stays ready while it is asserted.
  assign bus.in_ready = bus.flush || !valid_r || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready && !bus.flush;
  assign xfer         = valid_r && bus.out_ready && !bus.flush;
  assign target       = cond_taken ? bus.pc + bus.imm : bus.pc + XLEN'(PC_STEP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r    <= 1'b0;
      taken_r    <= 1'b0;
      mis_r      <= 1'b0;
      redirect_r <= '0;
    end else begin
      if (bus.flush)   valid_r <= 1'b0;
      else if (accept) valid_r <= 1'b1;
      else if (xfer)   valid_r <= 1'b0;
      if (accept) begin
        taken_r    <= cond_taken;
        mis_r      <= (cond_taken != bus.pred_taken);
        redirect_r <= target;
      end
    end
  end

  assign bus.out_valid   = valid_r;
  assign bus.taken       = taken_r;
  assign bus.mispredict  = mis_r;
  assign bus.redirect_pc = redirect_r;

`ifdef BRANCH_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             held_branch;
  logic [CNT_W-1:0] br_cnt_r;
  logic [CNT_W-1:0] mis_cnt_r;

  // Counting happens on the outgoing transfer, so flushed results are never seen here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_branch <= 1'b0;
      br_cnt_r    <= '0;
      mis_cnt_r   <= '0;
    end else begin
      if (accept) held_branch <= bus.is_branch;
      if (bus.stats_clr) begin
        br_cnt_r  <= '0;
        mis_cnt_r <= '0;
      end else if (xfer) begin
        if (held_branch && br_cnt_r != CNT_MAX) br_cnt_r  <= br_cnt_r + 1'b1;
        if (mis_r && mis_cnt_r != CNT_MAX)      mis_cnt_r <= mis_cnt_r + 1'b1;
      end
    end
  end

  assign bus.br_cnt  = br_cnt_r;
  assign bus.mis_cnt = mis_cnt_r;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: directed vector table, hand-written handshake/flush/reset
// sequences, and random traffic against a queue-based reference model.
module tb_branch_resolve;
  import branch_resolve_pkg::*;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam int RW    = XLEN + 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_resolve_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();
  branch_resolve #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;

  // Scoreboard: results held by the stage, {is_branch, taken, mispredict, redirect_pc}
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] last_res;
  int            m_br;
  int            m_mis;

  typedef struct {
    logic        isbr;
    logic [2:0]  bt;
    logic [31:0] a, b, pc, imm;
    logic        pred;
    logic        et, em;
    logic [31:0] er;
  } vec_t;
  vec_t tv[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] ref_result(input logic isbr, input logic [2:0] bt,
      input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
      input logic [31:0] imm, input logic pred);
    longint sa, sb, ua, ub;
    logic t;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    t = 1'b0;
    if (isbr) begin
      case (bt)
        3'd0: t = (ua == ub);
        3'd1: t = (ua != ub);
        3'd4: t = (sa < sb);
        3'd5: t = (sa >= sb);
        3'd6: t = (ua < ub);
        3'd7: t = (ua >= ub);
        default: t = 1'b0;
      endcase
    end
    r = t ? 32'((ua + longint'({32'd0, imm})) % (64'd1 << 32)) : 32'((ua * 0) + longint'({32'd0, pc}) + 4);
    if (t) r = 32'((longint'({32'd0, pc}) + longint'({32'd0, imm})) % (64'd1 << 32));
    return {isbr, t, (t != pred), r};
  endfunction

  task automatic check_outputs();
    chk("out_valid", bus.out_valid, exp_q.size() != 0);
    chk("taken", bus.taken, last_res[XLEN+1]);
    chk("mispredict", bus.mispredict, last_res[XLEN]);
    chk("redirect_pc", bus.redirect_pc, last_res[XLEN-1:0]);
`ifdef BRANCH_STATS_EN
    chk("br_cnt", bus.br_cnt, m_br);
    chk("mis_cnt", bus.mis_cnt, m_mis);
`endif
  endtask

  task automatic model_reset();
    exp_q.delete();
    last_res = '0;
    m_br     = 0;
    m_mis    = 0;
  endtask

  task automatic set_idle();
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    bus.flush      = 1'b0;
    bus.is_branch  = 1'b0;
    bus.br_type    = 3'd0;
    bus.rs1        = '0;
    bus.rs2        = '0;
    bus.pc         = '0;
    bus.imm        = '0;
    bus.pred_taken = 1'b0;
`ifdef BRANCH_STATS_EN
    bus.stats_clr  = 1'b0;
`endif
  endtask

  task automatic drv(input logic isbr, input logic [2:0] bt, input logic [31:0] a,
      input logic [31:0] b, input logic [31:0] pc, input logic [31:0] imm, input logic pred);
    bus.in_valid   = 1'b1;
    bus.is_branch  = isbr;
    bus.br_type    = bt;
    bus.rs1        = a;
    bus.rs2        = b;
    bus.pc         = pc;
    bus.imm        = imm;
    bus.pred_taken = pred;
  endtask

  // One clock: check in_ready, step the model with the pre-edge inputs, check registered outputs.
  task automatic tick();
    logic rdy, acc, xf, clr;
    logic [RW-1:0] res, head;
    #1;
    rdy = bus.flush || exp_q.size() == 0 || bus.out_ready;
    chk("in_ready", bus.in_ready, rdy);
    acc = bus.in_valid && rdy && !bus.flush;
    xf  = exp_q.size() != 0 && bus.out_ready && !bus.flush;
    res = ref_result(bus.is_branch, bus.br_type, bus.rs1, bus.rs2, bus.pc, bus.imm, bus.pred_taken);
    head = (exp_q.size() != 0) ? exp_q[0] : '0;
`ifdef BRANCH_STATS_EN
    clr = bus.stats_clr;
`else
    clr = 1'b0;
`endif
    @(posedge clk);
    if (clr) begin
      m_br  = 0;
      m_mis = 0;
    end else if (xf) begin
      if (head[XLEN+2]) m_br  = (m_br  < 15) ? m_br  + 1 : 15;
      if (head[XLEN])   m_mis = (m_mis < 15) ? m_mis + 1 : 15;
    end
    if ((bus.flush || xf) && exp_q.size() != 0) void'(exp_q.pop_front());
    if (acc) begin
      exp_q.push_back(res);
      last_res = res;
    end
    #1;
    check_outputs();
  endtask

  initial begin
    set_idle();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;

    // Directed vectors, one result per cycle with the consumer always ready
    tv[0] = '{1'b1, 3'b100, 32'hFFFFFFFF, 32'h1, 32'h100, 32'h20, 1'b0, 1'b1, 1'b1, 32'h120};
    tv[1] = '{1'b1, 3'b110, 32'hFFFFFFFF, 32'h1, 32'h100, 32'h20, 1'b0, 1'b0, 1'b0, 32'h104};
    tv[2] = '{1'b1, 3'b000, 32'h5, 32'h5, 32'h200, 32'hFFFFFFF0, 1'b1, 1'b1, 1'b0, 32'h1F0};
    tv[3] = '{1'b1, 3'b001, 32'h5, 32'h5, 32'h200, 32'h8, 1'b1, 1'b0, 1'b1, 32'h204};
    tv[4] = '{1'b1, 3'b101, 32'h80000000, 32'h7FFFFFFF, 32'h300, 32'h40, 1'b0, 1'b0, 1'b0, 32'h304};
    tv[5] = '{1'b1, 3'b111, 32'h80000000, 32'h7FFFFFFF, 32'h300, 32'h40, 1'b0, 1'b1, 1'b1, 32'h340};
    tv[6] = '{1'b0, 3'b000, 32'h3, 32'h3, 32'hFFFFFFFC, 32'h8, 1'b1, 1'b0, 1'b1, 32'h0};
    tv[7] = '{1'b1, 3'b010, 32'h3, 32'h3, 32'h10, 32'h4, 1'b0, 1'b0, 1'b0, 32'h14};
    tv[8] = '{1'b1, 3'b101, 32'h7, 32'h7, 32'h0, 32'h10, 1'b1, 1'b1, 1'b0, 32'h10};
    tv[9] = '{1'b1, 3'b100, 32'h1, 32'h2, 32'hFFFFFFF0, 32'h20, 1'b1, 1'b1, 1'b0, 32'h10};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drv(tv[i].isbr, tv[i].bt, tv[i].a, tv[i].b, tv[i].pc, tv[i].imm, tv[i].pred);
      tick();
      chk("tv_valid", bus.out_valid, 1'b1);
      chk("tv_taken", bus.taken, tv[i].et);
      chk("tv_mispredict", bus.mispredict, tv[i].em);
      chk("tv_redirect", bus.redirect_pc, tv[i].er);
    end
    set_idle();
    bus.out_ready = 1'b1;
    tick();

    // Backpressure: result held for three cycles, then drained and reloaded on one edge
    set_idle();
    drv(1'b1, BR_BEQ, 32'h9, 32'h9, 32'h400, 32'h8, 1'b0);
    tick();
    drv(1'b1, BR_BNE, 32'h1, 32'h2, 32'h500, 32'h10, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_in_ready", bus.in_ready, 1'b0);
      chk("hold_redirect", bus.redirect_pc, 32'h408);
      chk("hold_taken", bus.taken, 1'b1);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("reload_valid", bus.out_valid, 1'b1);
    chk("reload_redirect", bus.redirect_pc, 32'h510);
    chk("reload_mispredict", bus.mispredict, 1'b0);
    set_idle();
    bus.out_ready = 1'b1;
    tick();

    // Flush while holding, with a request offered during the flush
    set_idle();
    drv(1'b1, BR_BLTU, 32'h1, 32'h2, 32'h600, 32'h20, 1'b0);
    tick();
    bus.flush = 1'b1;
    drv(1'b1, BR_BEQ, 32'h1, 32'h1, 32'h700, 32'h8, 1'b0);
    #1;
    chk("flush_in_ready", bus.in_ready, 1'b1);
    tick();
    chk("flush_valid", bus.out_valid, 1'b0);
    chk("flush_redirect", bus.redirect_pc, 32'h620);
    set_idle();
    tick();

`ifdef BRANCH_STATS_EN
    // Counter saturation, then clear racing a counted transfer
    set_idle();
    bus.stats_clr = 1'b1;
    tick();
    bus.stats_clr = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drv(1'b1, BR_BEQ, 32'h1, 32'h2, 32'h800 + 32'(i * 4), 32'h40, 1'b1);
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    chk("sat_br_cnt", bus.br_cnt, 4'hF);
    chk("sat_mis_cnt", bus.mis_cnt, 4'hF);
    drv(1'b1, BR_BEQ, 32'h1, 32'h2, 32'h900, 32'h40, 1'b1);
    tick();
    bus.in_valid  = 1'b0;
    bus.stats_clr = 1'b1;
    tick();
    chk("clr_br_cnt", bus.br_cnt, 4'h0);
    chk("clr_mis_cnt", bus.mis_cnt, 4'h0);
    bus.stats_clr = 1'b0;
`endif

    // Asynchronous reset while a result is held
    set_idle();
    drv(1'b1, BR_BGE, 32'h5, 32'h1, 32'hA00, 32'h10, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_valid", bus.out_valid, 1'b0);
    chk("rst_async_redirect", bus.redirect_pc, 32'h0);
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    drv(1'b0, 3'd0, 32'h0, 32'h0, 32'hFFFFFFFC, 32'h0, 1'b1);
    bus.out_ready = 1'b1;
    tick();
    chk("post_rst_valid", bus.out_valid, 1'b1);
    chk("post_rst_redirect", bus.redirect_pc, 32'h0);
    chk("post_rst_mispredict", bus.mispredict, 1'b1);

    // Random traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a;
      set_idle();
      a = $urandom();
      drv($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), a,
          ($urandom_range(0, 2) == 0) ? a : $urandom(), $urandom(), $urandom(),
          1'($urandom_range(0, 1)));
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.flush     = ($urandom_range(0, 15) == 0);
`ifdef BRANCH_STATS_EN
      bus.stats_clr = ($urandom_range(0, 31) == 0);
`endif
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
